serial_adder: RTL and testbench

Bit-serial adder built around a half-adder pair and a carry flip-flop. It is the sequential stage that consumes the combinational half-adder cell. It accepts two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock. It then presents a registered sum and carry-out with a one-cycle done pulse. It is used where area matters more than latency and feeds downstream accumulators through the done handshake.

---
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first.
// Ports: clk, rst_n, start, a, b -> busy, done, sum, carry, ovf
// (ovf exists only with SERIAL_ADDER_OVF_EN defined).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_s;
  logic c_nx;
  logic last_s;

  assign bit_s  = sa_q[0] ^ sb_q[0] ^ c_q;
  assign c_nx   = (sa_q[0] & sb_q[0])
                | (c_q & (sa_q[0] ^ sb_q[0]));
  assign last_s = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          ps_d    = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        ps_d  = {bit_s, ps_q[WIDTH-1:1]};
        c_d   = c_nx;
        cnt_d = cnt_q + CW'(1);
        if (last_s) begin
          sum_d   = {bit_s, ps_q[WIDTH-1:1]};
          carry_d = c_nx;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on the final bit
          ovf_d   = c_q ^ c_nx;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8).
// Reference model + directed literal checks.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;

  int tests;
  int fails;
  bit chk_en;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: an accepted op finishes W edges later
  // with result a+b; results hold until replaced.
  int           rem;
  logic [W:0]   pend;
  logic         pend_ovf;
  logic         m_done;
  logic [W-1:0] m_sum;
  logic         m_carry;
  logic         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= 0;
      pend    <= '0;
      pend_ovf <= 1'b0;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_carry <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      automatic int   r = rem;
      automatic logic [W:0] s;
      automatic bit   acc = (rem == 0) && start;
      m_done <= 1'b0;
      if (r > 0) begin
        r = r - 1;
        if (r == 0) begin
          m_done  <= 1'b1;
          m_sum   <= pend[W-1:0];
          m_carry <= pend[W];
          m_ovf   <= pend_ovf;
        end
      end
      if (acc) begin
        s = {1'b0, a} + {1'b0, b};
        pend     <= s;
        pend_ovf <= (a[W-1] == b[W-1]) &&
                    (s[W-1] != a[W-1]);
        r = W;
      end
      rem <= r;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (rem != 0));
      check("done", done, m_done);
      check("sum", sum, m_sum);
      check("carry", carry, m_carry);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", ovf, m_ovf);
`endif
      check("busy_done_excl", busy & done, 1'b0);
    end
  end

  // Drive an op at the current negedge; returns at
  // the negedge where done is seen. poke>0 pulses a
  // stray start on that RUN cycle.
  task automatic run_op(logic [W-1:0] av,
                        logic [W-1:0] bv,
                        logic [W-1:0] es,
                        logic ec, logic eo,
                        int poke, bit lit);
    int n;
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    while (!done && n < W + 4) begin
      if (n == poke) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, W);
    check("lit_sum", sum, es);
    check("lit_carry", carry, ec);
`ifdef SERIAL_ADDER_OVF_EN
    if (lit) check("lit_ovf", ovf, eo);
`else
    if (lit) check("lit_ovf_absent", ovf, 1'b0);
`endif
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W:0] s;
    logic [W-1:0] ra, rb;
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    idle(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_carry", carry, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, -1, 1);
    idle(2);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, -1, 1);
    idle(1);
    run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, -1, 1);
    idle(3);
    run_op(8'h3C, 8'hA5, 8'hE1, 1'b0, 1'b0, 2, 1);
    idle(2);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, -1, 1);
    run_op(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, -1, 1);
    idle(2);

    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    idle(4);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_carry", carry, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(W + 2);
    check("abort_nodone_sum", sum, 8'h00);
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, -1, 1);
    idle(1);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      s  = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, s[W-1:0], s[W], 1'b0, -1, 0);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
